// File: rtl/instr_compact_queue_pkg.sv
// Shared definitions for the instruction compaction queue: a minimal core
// configuration record and small elaboration-time helpers.
package instr_compact_queue_pkg;

  // Core configuration subset used by the queue.
  typedef struct packed {
    int unsigned VLEN;
    int unsigned INSTR_PER_FETCH;
  } cfg_t;

  localparam cfg_t IcqCfgDefault = '{VLEN: 32, INSTR_PER_FETCH: 2};

  // Width of an instruction slot; compressed instructions arrive zero-extended.
  localparam int unsigned IcqInstrW = 32;

  // Bits needed to hold a value in 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/instr_compact_queue_lane_compactor.sv
// Prefix popcount over the per-lane valid mask. Each lane gets the number of
// valid lanes below it (its slot offset from the write pointer) and the total
// tells the parent how far to advance the write pointer.
module instr_lane_compactor
  import instr_compact_queue_pkg::*;
#(
  parameter int unsigned NrLanes = 2,
  parameter int unsigned CntW    = cnt_width(NrLanes)
) (
  input  logic [NrLanes-1:0]           valid_i,
  output logic [NrLanes-1:0][CntW-1:0] offset_o,
  output logic [CntW-1:0]              total_o
);

  // Running sum in lane order: lower lanes are older and take lower slots.
  always_comb begin
    logic [CntW-1:0] acc;
    acc      = '0;
    offset_o = '0;
    for (int i = 0; i < int'(NrLanes); i++) begin
      offset_o[i] = acc;
      acc         = acc + CntW'(valid_i[i]);
    end
    total_o = acc;
  end

endmodule

// File: rtl/instr_compact_queue.sv
// Instruction compaction queue between the realigner and decode. Sparse
// per-lane fetch results are packed in lane order into a circular buffer and
// handed to decode one per cycle over valid/ready.
module instr_compact_queue
  import instr_compact_queue_pkg::*;
#(
  parameter cfg_t        CVA6Cfg = IcqCfgDefault,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_ni,
  input  logic                                                   flush_i,
  input  logic [CVA6Cfg.INSTR_PER_FETCH-1:0]                     valid_i,
  input  logic [CVA6Cfg.INSTR_PER_FETCH-1:0][CVA6Cfg.VLEN-1:0]   addr_i,
  input  logic [CVA6Cfg.INSTR_PER_FETCH-1:0][IcqInstrW-1:0]      instr_i,
  output logic                                                   ready_o,
  output logic                                                   valid_o,
  output logic [CVA6Cfg.VLEN-1:0]                                addr_o,
  output logic [IcqInstrW-1:0]                                   instr_o,
  input  logic                                                   ready_i,
  output logic [$clog2(DEPTH):0]                                 count_o
);

  localparam int unsigned NrLanes  = CVA6Cfg.INSTR_PER_FETCH;
  localparam int unsigned Vlen     = CVA6Cfg.VLEN;
  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam int unsigned LaneCntW = cnt_width(NrLanes);

  // A full fetch must always fit twice so ready_o can stay high while decode drains.
  if (!is_pow2(DEPTH) || (DEPTH < 2 * NrLanes)) begin : g_bad_cfg
    $fatal(1, "instr_compact_queue: DEPTH must be a power of 2 and >= 2*INSTR_PER_FETCH");
  end

  typedef struct packed {
    logic [Vlen-1:0]      addr;
    logic [IcqInstrW-1:0] instr;
  } entry_t;

  entry_t              storage_reg [DEPTH];
  logic [PtrW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PtrW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CntW-1:0]     count_reg,  count_next;

  logic [NrLanes-1:0]                push_mask;
  logic [NrLanes-1:0][LaneCntW-1:0]  lane_offset;
  logic [LaneCntW-1:0]               push_cnt;
  logic [NrLanes-1:0][PtrW-1:0]      wr_idx;
  logic                              pop;

  // Space check uses registered count only, so upstream sees no combinational loop.
  assign ready_o   = (CntW'(DEPTH) - count_reg) >= CntW'(NrLanes);
  // Input offered while full is dropped here; upstream is expected to replay it.
  assign push_mask = ready_o ? valid_i : '0;
  assign valid_o   = (count_reg != '0);
  assign pop       = valid_o && ready_i;

  instr_lane_compactor #(
    .NrLanes (NrLanes),
    .CntW    (LaneCntW)
  ) u_compactor (
    .valid_i  (push_mask),
    .offset_o (lane_offset),
    .total_o  (push_cnt)
  );

  // Per-lane target slot; the add wraps naturally across DEPTH-1 -> 0.
  for (genvar gi = 0; gi < int'(NrLanes); gi++) begin : g_wr_idx
    assign wr_idx[gi] = wr_ptr_reg + PtrW'(lane_offset[gi]);
  end

  // Pointer/count update; flush overrides any push or pop in the same cycle.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      wr_ptr_next = wr_ptr_reg + PtrW'(push_cnt);
      rd_ptr_next = rd_ptr_reg + PtrW'(pop);
      count_next  = count_reg + CntW'(push_cnt) - CntW'(pop);
    end
  end

  // Queue state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entry storage: cleared by reset only, a flush leaves stale contents behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < int'(DEPTH); e++) begin
        storage_reg[e] <= '0;
      end
    end else if (!flush_i) begin
      for (int l = 0; l < int'(NrLanes); l++) begin
        if (push_mask[l]) begin
          storage_reg[wr_idx[l]] <= '{addr: addr_i[l], instr: instr_i[l]};
        end
      end
    end
  end

  // Head is read straight from storage; a fresh push shows up one cycle later.
  assign addr_o  = storage_reg[rd_ptr_reg].addr;
  assign instr_o = storage_reg[rd_ptr_reg].instr;
  assign count_o = count_reg;

  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_reg <= CntW'(DEPTH));

  a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && (count_reg == '0)));

endmodule
